// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RISC-V M-extension multiply/divide unit.
//   Multiplies with shift-add and divides with restoring division, one radix-2
//   step per cycle on operand magnitudes. Signs are applied to the final value.
//   Divide-by-zero and signed overflow respond one cycle after accept.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   req_valid_i/_o    - request handshake (req_ready_o high only when idle)
//   funct3_i          - M-extension operation select
//   rs1_i, rs2_i      - operands, captured at accept
//   flush_i           - abort in-flight operation, blocks accept while idle
//   resp_valid_o/_i   - response handshake; result_o held until consumed
//   result_o          - result, zero whenever resp_valid_o is low
//   busy_o            - high whenever the unit is not idle
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  // Two's-complement negation of a 32-bit value.
  function automatic logic [31:0] f_neg32(input logic [31:0] v);
    return (~v) + 32'd1;
  endfunction

  state_t       r_state;
  logic [4:0]   r_cnt;
  logic [2:0]   r_funct3;
  logic         r_neg;
  logic [31:0]  r_hi;     // product high half / partial remainder
  logic [31:0]  r_lo;     // product low half + multiplier / dividend + quotient
  logic [31:0]  r_opd;    // multiplicand / divisor magnitude
  logic         r_req_ready;
  logic         r_resp_valid;
  logic         r_busy;
  logic [31:0]  r_result;

  logic         w_sa, w_sb, w_neg_init, w_div_zero, w_ovf, w_special;
  logic [31:0]  w_mag_a, w_mag_b, w_special_res;
  logic [32:0]  w_sum, w_trial;
  logic [31:0]  w_next_hi, w_next_lo, w_final;
  logic [63:0]  w_prod, w_prod_s;

  // Accept-time decode: operand signs, magnitudes and divide special cases.
  always_comb begin
    w_sa = 1'b0;
    w_sb = 1'b0;
    if (funct3_i[2]) begin
      // DIV/REM are signed, DIVU/REMU are not
      w_sa = ~funct3_i[0] & rs1_i[31];
      w_sb = ~funct3_i[0] & rs2_i[31];
    end else begin
      // rs1 signed for MULH/MULHSU, rs2 signed only for MULH; MUL uses raw bits
      w_sa = ((funct3_i[1:0] == 2'b01) || (funct3_i[1:0] == 2'b10)) & rs1_i[31];
      w_sb = (funct3_i[1:0] == 2'b01) & rs2_i[31];
    end
    w_mag_a = w_sa ? f_neg32(rs1_i) : rs1_i;
    w_mag_b = w_sb ? f_neg32(rs2_i) : rs2_i;
    // remainder follows the dividend sign; everything else the sign product
    if (funct3_i[2] && funct3_i[1]) begin
      w_neg_init = w_sa;
    end else begin
      w_neg_init = w_sa ^ w_sb;
    end
    w_div_zero = funct3_i[2] & (rs2_i == 32'h0000_0000);
    w_ovf      = funct3_i[2] & ~funct3_i[0] & (rs1_i == 32'h8000_0000) &
                 (rs2_i == 32'hFFFF_FFFF);
    w_special  = w_div_zero | w_ovf;
    if (w_div_zero) begin
      w_special_res = funct3_i[1] ? rs1_i : 32'hFFFF_FFFF;
    end else begin
      w_special_res = funct3_i[1] ? 32'h0000_0000 : 32'h8000_0000;
    end
  end

  // One radix-2 step plus the sign-corrected result of the last step.
  always_comb begin
    w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opd} : 33'd0);
    w_trial = {r_hi, r_lo[31]} - {1'b0, r_opd};
    if (r_funct3[2]) begin
      // restoring divide: keep the trial difference only if it did not borrow
      if (!w_trial[32]) begin
        w_next_hi = w_trial[31:0];
      end else begin
        w_next_hi = {r_hi[30:0], r_lo[31]};
      end
      w_next_lo = {r_lo[30:0], ~w_trial[32]};
    end else begin
      // shift-add: add multiplicand to the high half, shift the pair right
      w_next_hi = w_sum[32:1];
      w_next_lo = {w_sum[0], r_lo[31:1]};
    end
    w_prod   = {w_next_hi, w_next_lo};
    w_prod_s = r_neg ? ((~w_prod) + 64'd1) : w_prod;
    case (r_funct3)
      3'b000:                 w_final = w_prod_s[31:0];
      3'b001, 3'b010, 3'b011: w_final = w_prod_s[63:32];
      3'b100, 3'b101:         w_final = r_neg ? f_neg32(w_next_lo) : w_next_lo;
      3'b110, 3'b111:         w_final = r_neg ? f_neg32(w_next_hi) : w_next_hi;
      default:                w_final = 32'h0000_0000;
    endcase
  end

  // Control FSM with registered handshake, busy and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 5'd0;
      r_funct3     <= 3'd0;
      r_neg        <= 1'b0;
      r_hi         <= 32'd0;
      r_lo         <= 32'd0;
      r_opd        <= 32'd0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_result     <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!flush_i && req_valid_i && r_req_ready) begin
            r_funct3    <= funct3_i;
            r_cnt       <= 5'd0;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (w_special) begin
              r_state      <= S_DONE;
              r_resp_valid <= 1'b1;
              r_result     <= w_special_res;
            end else begin
              r_state <= S_BUSY;
              r_hi    <= 32'd0;
              r_lo    <= w_mag_a;
              r_opd   <= w_mag_b;
              r_neg   <= w_neg_init;
            end
          end
        end
        S_BUSY: begin
          if (flush_i) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
          end else begin
            r_hi  <= w_next_hi;
            r_lo  <= w_next_lo;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) begin
              r_state      <= S_DONE;
              r_resp_valid <= 1'b1;
              r_result     <= w_final;
            end
          end
        end
        S_DONE: begin
          if (flush_i || resp_ready_i) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_resp_valid <= 1'b0;
            r_result     <= 32'd0;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_req_ready  <= 1'b1;
          r_busy       <= 1'b0;
          r_resp_valid <= 1'b0;
          r_result     <= 32'd0;
        end
      endcase
    end
  end

  assign req_ready_o  = r_req_ready;
  assign resp_valid_o = r_resp_valid;
  assign result_o     = r_result;
  assign busy_o       = r_busy;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed testbench for mul_div_unit with hand-computed expected values.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic        flush_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] result_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .funct3_i(funct3_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .flush_i(flush_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .result_o(result_o), .busy_o(busy_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present a request and let the next rising edge accept it; operands are
  // scrambled afterwards to show they are only sampled at accept.
  task automatic issue(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b);
    funct3_i    = f3;
    rs1_i       = a;
    rs2_i       = b;
    req_valid_i = 1'b1;
    check({tag, "_rdy"}, {31'd0, req_ready_o}, 32'd1);
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    funct3_i    = 3'($urandom);
    rs1_i       = $urandom;
    rs2_i       = $urandom;
  endtask

  // Count cycles after accept until resp_valid_o (cycle 1 = right after accept).
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid_o && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_resp(input string tag);
    resp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    resp_ready_i = 1'b0;
    check({tag, "_vld0"}, {31'd0, resp_valid_o}, 32'd0);
    check({tag, "_idle"}, {30'd0, req_ready_o, busy_o}, 32'd2);
    check({tag, "_res0"}, result_o, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    issue(tag, f3, a, b);
    if (exp_lat > 1) begin
      check({tag, "_busy"}, {30'd0, req_ready_o, busy_o}, 32'd1);
      check({tag, "_res0"}, result_o, 32'd0);
    end
    wait_resp(lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, result_o, exp);
    release_resp(tag);
  endtask

  initial begin
    int lat;
    bit seen;
    rst = 1'b1; req_valid_i = 1'b0; funct3_i = 3'd0; rs1_i = 32'd0; rs2_i = 32'd0;
    flush_i = 1'b0; resp_ready_i = 1'b0;
    #12;
    check("rst_outs", {29'd0, resp_valid_o, busy_o, 1'b0}, 32'd0);
    check("rst_res", result_o, 32'd0);
    #4 rst = 1'b0;
    #1;
    check("rst_rdy", {31'd0, req_ready_o}, 32'd1);

    // multiply family
    run_op("mul",    3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run_op("mulh",   3'b001, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    run_op("mulhu2", 3'b011, 32'h8000_0000, 32'd4,         32'd2,         33);
    run_op("mul_big",3'b000, 32'd65537,    32'd65535,     32'hFFFF_FFFF, 33);
    // divide family
    run_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
    run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
    run_op("divu",   3'b101, 32'd100,       32'd7,         32'd14,        33);
    run_op("remu",   3'b111, 32'd100,       32'd7,         32'd2,         33);
    run_op("div_np", 3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    run_op("rem_np", 3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         33);
    run_op("divu_b", 3'b101, 32'hFFFF_FFFF, 32'd16,        32'h0FFF_FFFF, 33);
    // special cases
    run_op("divu0",  3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    run_op("rem0",   3'b110, 32'd5,         32'd0,         32'd5,         1);
    run_op("div_ov", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ov", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

    // backpressure: result held for 10 cycles, then a single ready pulse
    issue("hold", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_resp(lat);
    check("hold_lat", lat, 33);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("hold_res", result_o, 32'hFFFF_FFFE);
      check("hold_flags", {29'd0, resp_valid_o, req_ready_o, busy_o}, 32'd5);
    end
    resp_ready_i = 1'b1;
    req_valid_i  = 1'b1;
    funct3_i     = 3'b000;
    @(posedge clk);
    #1;
    resp_ready_i = 1'b0;
    req_valid_i  = 1'b0;
    check("hold_rel", {29'd0, resp_valid_o, req_ready_o, busy_o}, 32'd2);
    @(posedge clk);
    #1;
    check("hold_noacc", {31'd0, busy_o}, 32'd0);

    // flush while idle blocks accept
    flush_i = 1'b1;
    req_valid_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    req_valid_i = 1'b0;
    check("flush_idle", {30'd0, req_ready_o, busy_o}, 32'd2);

    // flush at iteration 10
    issue("flush", 3'b000, 32'd9, 32'd9);
    repeat (10) @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    check("flush_busy", {29'd0, resp_valid_o, req_ready_o, busy_o}, 32'd2);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (resp_valid_o) seen = 1'b1;
    end
    check("flush_noresp", {31'd0, seen}, 32'd0);

    // flush while a special-case response waits
    issue("flushd", 3'b101, 32'd5, 32'd0);
    check("flushd_vld", {31'd0, resp_valid_o}, 32'd1);
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    check("flushd_idle", {29'd0, resp_valid_o, req_ready_o, busy_o}, 32'd2);

    // asynchronous reset at iteration 20, then MUL 3x4 right after
    issue("rstmid", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (20) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rstmid_outs", {30'd0, resp_valid_o, busy_o}, 32'd0);
    check("rstmid_res", result_o, 32'd0);
    #2;
    rst = 1'b0;
    run_op("mul34", 3'b000, 32'd3, 32'd4, 32'd12, 33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%h exp=%h", 32'd1, 32'd0);
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid_i  input  1  an operation request is presented.
REQ-005 SHALL have port req_ready_o  output  1  unit can accept a request this cycle.
REQ-006 SHALL have port funct3_i  input  3  M-extension op: MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111.
REQ-007 SHALL have port rs1_i  input  XLEN  first operand (multiplicand/dividend).
REQ-008 SHALL have port rs2_i  input  XLEN  second operand (multiplier/divisor).
REQ-009 SHALL have port flush_i  input  1  abort any in-flight operation (pipeline flush).
REQ-010 SHALL have port resp_valid_o  output  1  result_o is valid.
REQ-011 SHALL have port resp_ready_i  input  1  consumer accepts result.
REQ-012 SHALL have port result_o  output  XLEN  operation result.
REQ-013 SHALL have port busy_o  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-015 SHALL assert req_ready_o only in IDLE; accept = req_valid_i & req_ready_o at a rising edge; funct3_i, rs1_i, rs2_i captured at accept and ignored otherwise.
REQ-016 SHALL on accept: IDLE->BUSY with 5-bit iteration counter = 0, except divide special cases (REQ-021/022) go IDLE->DONE directly.
REQ-017 SHALL in BUSY perform exactly one radix-2 iteration per cycle (shift-add multiply or restoring divide on magnitudes); after iteration 31 (counter wrap 31->0) transition BUSY->DONE.
REQ-018 SHALL assert resp_valid_o only in DONE; normal latency: resp_valid_o high in the 33rd cycle after the accept edge; special-case latency: 1 cycle.
REQ-019 SHALL hold result_o and resp_valid_o stable in DONE until resp_ready_i; DONE->IDLE on resp_valid_o & resp_ready_i; a new request is not accepted in that same cycle.
REQ-020 Multiply: 64-bit product; MUL returns bits[31:0]; MULH signed x signed, MULHSU signed rs1 x unsigned rs2, MULHU unsigned x unsigned return bits[63:32]; signs handled by magnitude operation plus two's-complement negation of the 64-bit product.
REQ-021 Divide by zero (rs2=0): DIV/DIVU quotient = 0xFFFFFFFF; REM/REMU remainder = rs1.
REQ-022 Signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
REQ-023 DIV truncates toward zero; REM takes the sign of the dividend; DIVU/REMU unsigned.
REQ-024 SHALL treat flush_i as highest priority: in BUSY or DONE, next state IDLE, no response produced; flush_i in IDLE blocks accept that cycle.
REQ-025 result_o SHALL be 0 whenever resp_valid_o is low.

Reset
REQ-026 SHALL on rst, asynchronously and at any time including mid-operation: state=IDLE, counter=0, internal operand/accumulator registers=0, req_ready_o=1 after deassertion, resp_valid_o=0, busy_o=0, result_o=0.
REQ-027 SHALL accept a request on the first rising edge after rst deassertion.

Verification
REQ-028 MUL rs1=7, rs2=0xFFFFFFFD -> result_o=0xFFFFFFEB, resp_valid_o in 33rd cycle after accept; MULH same operands -> 0xFFFFFFFF.
REQ-029 MULHU rs1=rs2=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 0xFFFFFFFF.
REQ-030 DIV rs1=0xFFFFFFF9(-7), rs2=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
REQ-031 DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, both with resp_valid_o 1 cycle after accept; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-032 Hold resp_ready_i=0 for 10 cycles after resp_valid_o -> result_o stable, req_ready_o=0, busy_o=1 throughout; single resp_ready_i pulse -> IDLE next cycle.
REQ-033 flush_i at BUSY iteration 10 -> IDLE next cycle, no resp_valid_o; rst asserted at iteration 20 -> all outputs reset immediately; subsequent MUL 3x4 -> 12.
